// File: rtl/mc_cpu_core.sv
// Parametrised multi-cycle CPU core (FETCH/DECODE/EXEC/MEM/WB) behind a req/ack memory port.
// Optional build macro MC_CPU_R0_ZERO_EN: R0 is hard-wired to zero when defined.
module mc_cpu_core #(
  parameter int          DATA_W   = 16,
  parameter int          NREGS    = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [DATA_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  input  logic                      mem_ack,
  output logic [DATA_W-1:0]         pc,
  output logic [DATA_W-1:0]         instruction,
  output logic [NREGS*DATA_W-1:0]   rf_flat,
  output logic                      retired
);

  localparam int RA = $clog2(NREGS);
  localparam int IW = DATA_W - 3 - 2*RA;

`ifdef MC_CPU_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_LW   = 3'b100;
  localparam logic [2:0] OP_SW   = 3'b101;
  localparam logic [2:0] OP_ADDI = 3'b110;
  localparam logic [2:0] OP_BEQ  = 3'b111;

  logic [2:0]        state;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic [DATA_W-1:0] res;
  logic [DATA_W-1:0] rf [NREGS];

  logic [2:0]        op;
  logic [RA-1:0]     rd;
  logic [RA-1:0]     rs1;
  logic [RA-1:0]     rs2;
  logic [DATA_W-1:0] imm;

  assign op  = ir[DATA_W-1 -: 3];
  assign rd  = ir[DATA_W-4 -: RA];
  assign rs1 = ir[DATA_W-4-RA -: RA];
  assign rs2 = ir[IW-1 -: RA];
  assign imm = {{(DATA_W-IW){ir[IW-1]}}, ir[IW-1:0]};

  // res doubles as the latched memory address in MEM and as the load buffer afterwards
  assign mem_req   = reset_n && ((state == S_FETCH) || (state == S_MEM));
  assign mem_we    = reset_n && (state == S_MEM) && (op == OP_SW);
  assign mem_addr  = (state == S_MEM) ? res : pc;
  assign mem_wdata = opb;
  assign retired   = reset_n && ((state == S_WB) ||
                                 ((state == S_EXEC) && (op == OP_BEQ)) ||
                                 ((state == S_MEM) && (op == OP_SW) && mem_ack));

  assign instruction = ir;

  for (genvar i = 0; i < NREGS; i++) begin : g_flat
    assign rf_flat[i*DATA_W +: DATA_W] = rf[i];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_FETCH;
      pc    <= DATA_W'(RESET_PC);
      ir    <= '0;
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (mem_ack) begin
            ir    <= mem_rdata;
            pc    <= pc + DATA_W'(1);
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          opa   <= rf[rs1];
          opb   <= ((op == OP_SW) || (op == OP_BEQ)) ? rf[rd] : rf[rs2];
          state <= S_EXEC;
        end
        S_EXEC: begin
          case (op)
            OP_ADD:  begin res <= opa + opb;  state <= S_WB;  end
            OP_SUB:  begin res <= opa - opb;  state <= S_WB;  end
            OP_AND:  begin res <= opa & opb;  state <= S_WB;  end
            OP_OR:   begin res <= opa | opb;  state <= S_WB;  end
            OP_ADDI: begin res <= opa + imm;  state <= S_WB;  end
            OP_LW,
            OP_SW:   begin res <= opa + imm;  state <= S_MEM; end
            default: begin
              // pc was already advanced past the branch in FETCH
              if (opa == opb) pc <= pc + imm;
              state <= S_FETCH;
            end
          endcase
        end
        S_MEM: begin
          if (mem_ack) begin
            if (op == OP_SW) begin
              state <= S_FETCH;
            end else begin
              res   <= mem_rdata;
              state <= S_WB;
            end
          end
        end
        S_WB: begin
          if (!(R0_ZERO && (rd == '0))) rf[rd] <= res;
          state <= S_FETCH;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: doc/mc_cpu_core.md
# mc_cpu_core

Parametrised multi-cycle CPU core: the next generation of the team's 16-bit, 4-register FETCH/DECODE/EXEC/MEM/WB processor. Data width and register count are configurable. Memory is external behind a req/ack handshake, so wait states of any length are tolerated. A BEQ branch is added, and register contents are exported as a flat debug bus. The core sits under the system top, between the shared instruction/data memory and the debug/LED logic.

## Interface
- DATA_W, 16, data, instruction and address width (min 12)
- NREGS, 4, register count (power of 2, 2..16); RA = clog2(NREGS)
- RESET_PC, 0, PC value after reset
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  write strobe, valid with mem_req
- mem_addr  out  DATA_W  word address
- mem_wdata  out  DATA_W  store data
- mem_rdata  in  DATA_W  read data, sampled on the ack cycle
- mem_ack  in  1  request completes this cycle
- pc  out  DATA_W  current PC
- instruction  out  DATA_W  instruction register
- rf_flat  out  NREGS*DATA_W  register file; R[i] occupies bits [i*DATA_W +: DATA_W]
- retired  out  1  one-cycle pulse in an instruction's final cycle

## Operation
- Instruction fields, MSB first: op[3], rd[RA], rs1[RA], then the remainder. rs2 is the top RA bits of the remainder. imm is the whole remainder (IW = DATA_W-3-2*RA bits), sign-extended.
- Opcodes:
  - 000 ADD, 001 SUB, 010 AND, 011 OR: rd = rs1 op rs2.
  - 110 ADDI: rd = rs1 + imm.
  - 100 LW: rd = M[rs1+imm].
  - 101 SW: M[rs1+imm] = R[rd].
  - 111 BEQ: if R[rd]==R[rs1], then pc = pc+imm.
- All arithmetic is modulo 2^DATA_W. The address computation truncates.
- State machine:
  - FETCH: mem_req=1, mem_addr=pc. On ack: IR <= mem_rdata, pc <= pc+1, go to DECODE.
  - DECODE: operand read; go to EXEC.
  - EXEC:
    - ALU/ADDI: latch result, go to WB.
    - LW/SW: latch address, go to MEM.
    - BEQ: on taken, pc <= pc+imm (pc already incremented); pulse retired; go to FETCH.
  - MEM: mem_req=1, mem_addr=latched address, mem_we=1 for SW, mem_wdata=R[rd].
    - On ack, LW: capture mem_rdata into a buffer, go to WB.
    - On ack, SW: pulse retired, go to FETCH.
  - WB: write rd from the ALU result or the load buffer; pulse retired; go to FETCH.
- mem_ack is ignored whenever mem_req=0. mem_we=0 outside MEM/SW.
- mem_addr and mem_wdata hold stable while mem_req=1.

## Timing
- Reset values: state FETCH, pc=RESET_PC, IR=0, all registers 0, retired=0, mem_we=0. mem_req is forced 0 while reset_n=0.
- An assertion of reset_n mid-instruction abandons it. No register write or memory write completes after reset asserts.
- Cycles per instruction, with a memory ack latency of L≥0 cycles after req (L=0 means ack in the same cycle):
  - ALU/ADDI: 4+L.
  - BEQ: 3+L.
  - SW: 4+2L.
  - LW: 5+2L.
- The register write lands on the clk edge that ends WB. The next instruction's DECODE sees the new value.
- retired is high exactly one cycle per instruction.

## Configuration
- MC_CPU_R0_ZERO_EN defined: R0 reads as 0 and writes to R0 are discarded; rf_flat slot 0 is constantly 0.
- MC_CPU_R0_ZERO_EN undefined: R0 is an ordinary register.

## Test plan
- ADDI R1,R0,5 then ADD R2,R1,R1 with zero-wait memory:
  - R1=5, R2=10.
  - retired pulses at cycles 4 and 8 after reset release.
- SW R2→[R0+3], then LW R3,[R0+3] with ack delayed 3 cycles:
  - mem_req held with stable addr=3 and wdata=10.
  - R3=10; LW takes 11 cycles.
- BEQ R1,R1,imm=-2 at pc=4: pc becomes 3. With R1≠R2: pc becomes 5.
- DATA_W=32, NREGS=8: SUB giving 0-1 yields 0xFFFFFFFF. The sign-extended negative imm is correct.
- Assert reset_n low during LW MEM wait:
  - mem_req drops immediately; no register write.
  - After release, pc=RESET_PC and fetch restarts.
- With MC_CPU_R0_ZERO_EN, ADDI R0,R0,7: R0 stays 0. Without it: R0=7.
